// File: rtl/bit_deser_pkg.sv
// Shared definitions for the serial-to-parallel packer.
// Counter width helper and default counter type.
// No logic; imported by bit_deserializer.
package bit_deser_pkg;

  // Bits needed to count from 0 up to and including width
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int DEFAULT_WIDTH = 24;

  // Bit counter sized for the default word width
  typedef logic [cnt_w(DEFAULT_WIDTH)-1:0] bit_cnt_t;

endpackage

// File: rtl/bit_deserializer.sv
// Packs a 1-bit stream MSB-first into WIDTH-bit words; early flush emits a zero-padded partial word.
// Latency: strobe 1 clock after the last accepted bit (or flush); back-to-back words need no gap.
// No backpressure: every strobe is consumed. Optional BIT_DESER_PARITY_EN adds deser_parity_o.
module bit_deserializer
  import bit_deser_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic                      clk_i,
  input  logic                      arst_i,
  input  logic                      data_i,
  input  logic                      data_val_i,
  input  logic                      flush_i,
  output logic [WIDTH-1:0]          deser_data_o,
  output logic [cnt_w(WIDTH)-1:0]   deser_bits_o,
  output logic                      deser_data_val_o
`ifdef BIT_DESER_PARITY_EN
  ,
  output logic                      deser_parity_o
`endif
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    bits_q, bits_d;
  logic             val_q, val_d;
  logic [WIDTH-1:0] word;
  logic [CW-1:0]    cnt_n;
  logic             emit;
`ifdef BIT_DESER_PARITY_EN
  logic             par_run_q, par_run_d;
  logic             par_q, par_d;
  logic             par_n;
`endif

  // Insert the incoming bit, then decide whether this cycle closes a word
  always_comb begin
    word  = shift_q;
    cnt_n = cnt_q;
    if (data_val_i) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (i == WIDTH - 1 - int'(cnt_q)) word[i] = data_i;
      end
      cnt_n = cnt_q + CW'(1);
    end
    // A flush that lands on the final bit is just a full word
    emit = (cnt_n == FULL) || (flush_i && (cnt_n != '0));

    shift_d = word;
    cnt_d   = cnt_n;
    data_d  = data_q;
    bits_d  = bits_q;
    val_d   = 1'b0;
`ifdef BIT_DESER_PARITY_EN
    par_n     = par_run_q ^ (data_val_i & data_i);
    par_run_d = par_n;
    par_d     = par_q;
`endif
    if (emit) begin
      // Shift register is cleared at each emission, so unfilled low bits are already zero
      data_d  = word;
      bits_d  = cnt_n;
      val_d   = 1'b1;
      shift_d = '0;
      cnt_d   = '0;
`ifdef BIT_DESER_PARITY_EN
      par_d     = par_n;
      par_run_d = 1'b0;
`endif
    end
  end

  // State and registered outputs; reset discards any partial word
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      bits_q  <= '0;
      val_q   <= 1'b0;
`ifdef BIT_DESER_PARITY_EN
      par_run_q <= 1'b0;
      par_q     <= 1'b0;
`endif
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      bits_q  <= bits_d;
      val_q   <= val_d;
`ifdef BIT_DESER_PARITY_EN
      par_run_q <= par_run_d;
      par_q     <= par_d;
`endif
    end
  end

  assign deser_data_o     = data_q;
  assign deser_bits_o     = bits_q;
  assign deser_data_val_o = val_q;
`ifdef BIT_DESER_PARITY_EN
  assign deser_parity_o   = par_q;
`endif

endmodule

// File: tb/tb_bit_deserializer.sv
// Bench for bit_deserializer: WIDTH=8 and WIDTH=24 instances fed the same serial stream.
// Expected words are built from a bit list when stimulus is driven and checked on each strobe.
// Honours BIT_DESER_PARITY_EN when defined.
module tb_bit_deserializer;

  typedef struct {
    logic [23:0] data;
    int          bits;
    logic        par;
    int          ones;
    int          cyc;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        arst_i = 1'b1;
  logic        data_i = 1'b0;
  logic        data_val_i = 1'b0;
  logic        flush_i = 1'b0;

  logic [7:0]  data8;
  logic [3:0]  bits8;
  logic        val8;
  logic [23:0] data24;
  logic [4:0]  bits24;
  logic        val24;
`ifdef BIT_DESER_PARITY_EN
  logic        par8, par24;
`endif

  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  bit   mq8[$];
  bit   mq24[$];
  exp_t eq8[$];
  exp_t eq24[$];
  exp_t e8, e24;

  bit_deserializer #(.WIDTH(8)) u_dut8 (
    .clk_i            (clk_i),
    .arst_i           (arst_i),
    .data_i           (data_i),
    .data_val_i       (data_val_i),
    .flush_i          (flush_i),
    .deser_data_o     (data8),
    .deser_bits_o     (bits8),
    .deser_data_val_o (val8)
`ifdef BIT_DESER_PARITY_EN
    ,
    .deser_parity_o   (par8)
`endif
  );

  bit_deserializer #(.WIDTH(24)) u_dut24 (
    .clk_i            (clk_i),
    .arst_i           (arst_i),
    .data_i           (data_i),
    .data_val_i       (data_val_i),
    .flush_i          (flush_i),
    .deser_data_o     (data24),
    .deser_bits_o     (bits24),
    .deser_data_val_o (val24)
`ifdef BIT_DESER_PARITY_EN
    ,
    .deser_parity_o   (par24)
`endif
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Expected word from the list of bits collected since the last emission
  function automatic exp_t build(input bit bq[$], input int w, input int c);
    exp_t r;
    r.data = '0;
    r.par  = 1'b0;
    r.ones = 0;
    for (int i = 0; i < bq.size(); i++) begin
      r.data[w-1-i] = bq[i];
      r.par  ^= bq[i];
      r.ones += int'(bq[i]);
    end
    r.bits = bq.size();
    r.cyc  = c;
    return r;
  endfunction

  // Drive one cycle of stimulus and record any word it should produce
  task automatic step(input logic v, input logic d, input logic f);
    data_val_i = v;
    data_i     = d;
    flush_i    = f;
    if (v) begin
      mq8.push_back(d);
      mq24.push_back(d);
    end
    if (mq8.size() == 8 || (f && mq8.size() > 0)) begin
      eq8.push_back(build(mq8, 8, cyc + 1));
      mq8.delete();
    end
    if (mq24.size() == 24 || (f && mq24.size() > 0)) begin
      eq24.push_back(build(mq24, 24, cyc + 1));
      mq24.delete();
    end
    @(posedge clk_i);
    #1;
    data_val_i = 1'b0;
    data_i     = 1'b0;
    flush_i    = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) step(1'b1, b[i], 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Strobe checker for the 8-bit instance
  always @(negedge clk_i) begin
    if (!arst_i && (val8 || (eq8.size() != 0 && eq8[0].cyc <= cyc))) begin
      if (eq8.size() != 0 && eq8[0].cyc == cyc) begin
        e8 = eq8.pop_front();
        check("strobe8", 32'(val8), 32'(1));
        check("data8", 32'(data8), 32'(e8.data[7:0]));
        check("bits8", 32'(bits8), 32'(e8.bits));
        check("popcount8", 32'($countones(data8)), 32'(e8.ones));
`ifdef BIT_DESER_PARITY_EN
        check("parity8", 32'(par8), 32'(e8.par));
`endif
      end else begin
        check("spurious8", 32'(val8), 32'(0));
      end
    end
  end

  // Strobe checker for the 24-bit instance
  always @(negedge clk_i) begin
    if (!arst_i && (val24 || (eq24.size() != 0 && eq24[0].cyc <= cyc))) begin
      if (eq24.size() != 0 && eq24[0].cyc == cyc) begin
        e24 = eq24.pop_front();
        check("strobe24", 32'(val24), 32'(1));
        check("data24", 32'(data24), 32'(e24.data));
        check("bits24", 32'(bits24), 32'(e24.bits));
        check("popcount24", 32'($countones(data24)), 32'(e24.ones));
`ifdef BIT_DESER_PARITY_EN
        check("parity24", 32'(par24), 32'(e24.par));
`endif
      end else begin
        check("spurious24", 32'(val24), 32'(0));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] pat;
    #2;
    check("rst_data8", 32'(data8), 32'(0));
    check("rst_bits8", 32'(bits8), 32'(0));
    check("rst_val8", 32'(val8), 32'(0));
    check("rst_data24", 32'(data24), 32'(0));
    check("rst_val24", 32'(val24), 32'(0));
    #11;
    arst_i = 1'b0;
    @(posedge clk_i);
    #1;

    // Contiguous full word 1,0,1,1,0,0,1,0
    pat = 8'hB2;
    send_byte(pat);
    idle(3);
    check("hold_data8", 32'(data8), 32'(8'hB2));
    check("hold_bits8", 32'(bits8), 32'(8));

    // Back-to-back words
    send_byte(8'hFF);
    send_byte(8'h01);
    idle(2);

    // Partial flush then a fresh aligned word
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    send_byte(8'hA5);
    idle(2);

    // Flush with nothing held in the 8-bit instance
    step(1'b0, 1'b0, 1'b1);
    idle(2);

    // Flush coinciding with the 8th bit
    for (int i = 0; i < 7; i++) step(1'b1, 1'(i % 2), 1'b0);
    step(1'b1, 1'b1, 1'b1);
    idle(2);

    // Reset mid-word, pulsed between edges
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
    @(negedge clk_i);
    #1;
    arst_i = 1'b1;
    #1;
    check("arst_data8", 32'(data8), 32'(0));
    check("arst_bits8", 32'(bits8), 32'(0));
    check("arst_val8", 32'(val8), 32'(0));
    check("arst_data24", 32'(data24), 32'(0));
    arst_i = 1'b0;
    mq8.delete();
    mq24.delete();
    @(posedge clk_i);
    #1;
    send_byte(8'h3C);
    idle(2);

    // Random stream with gaps and occasional flushes
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 19) == 0));
    end
    step(1'b0, 1'b0, 1'b1);
    idle(4);

    check("drained8", 32'(eq8.size()), 32'(0));
    check("drained24", 32'(eq24.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
